// File: rtl/wb_unit_if.sv
// Bus bundle for wb_unit: ALU result port, load issue/response, and the register-file write port.
// The slave modport is the writeback unit's view; the master modport is the surrounding pipeline's view.
interface wb_unit_if;
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        alu_ready;

  logic        ld_issue_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_offset;
  logic        ld_issue_ready;

  logic        mem_rvalid;
  logic [31:0] mem_rdata;

  logic        is_write;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  logic        load_pending;
  logic [4:0]  load_rd;
  logic        err;

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    output alu_ready,
    input  ld_issue_valid, ld_rd, ld_funct3, ld_offset,
    output ld_issue_ready,
    input  mem_rvalid, mem_rdata,
    output is_write, wb_addr, wb_data,
    output load_pending, load_rd, err
  );

  modport master (
    output alu_valid, alu_rd, alu_data,
    input  alu_ready,
    output ld_issue_valid, ld_rd, ld_funct3, ld_offset,
    input  ld_issue_ready,
    output mem_rvalid, mem_rdata,
    input  is_write, wb_addr, wb_data,
    input  load_pending, load_rd, err
  );
endinterface

// File: rtl/wb_unit.sv
// Writeback arbiter: merges ALU results and single-outstanding load responses into one
// registered register-file write port, with load sign/zero extension.
//
// state     | meaning
// ----------+-------------------------------------------------------
// IDLE      | no load outstanding; any mem_rvalid here is an error
// LOAD_WAIT | one load outstanding; waiting for its memory response
module wb_unit (
  input  logic          clk,
  input  logic          rst,
  wb_unit_if.slave      bus
);

  typedef enum logic {IDLE, LOAD_WAIT} state_t;

  state_t      state_q, state_d;
  logic [4:0]  pend_rd_q, pend_rd_d;
  logic [2:0]  pend_f3_q, pend_f3_d;
  logic [1:0]  pend_off_q, pend_off_d;
  logic        is_write_q, is_write_d;
  logic [4:0]  wb_addr_q, wb_addr_d;
  logic [31:0] wb_data_q, wb_data_d;
  logic        err_q, err_d;

  logic        load_rsp;
  logic        ld_accept;
  logic        alu_accept;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic [31:0] load_ext;

  assign load_rsp   = (state_q == LOAD_WAIT) && bus.mem_rvalid;
  assign ld_accept  = bus.ld_issue_valid && bus.ld_issue_ready;
  assign alu_accept = bus.alu_valid && bus.alu_ready;

  assign bus.ld_issue_ready = (state_q == IDLE) || load_rsp;
  assign bus.alu_ready      = !load_rsp;
  assign bus.load_pending   = (state_q == LOAD_WAIT);
  assign bus.load_rd        = pend_rd_q;
  assign bus.is_write       = is_write_q;
  assign bus.wb_addr        = wb_addr_q;
  assign bus.wb_data        = wb_data_q;
  assign bus.err            = err_q;

  // Lane select for the response of the load captured at issue time.
  always_comb begin
    byte_sel = bus.mem_rdata[7:0];
    case (pend_off_q)
      2'd0: byte_sel = bus.mem_rdata[7:0];
      2'd1: byte_sel = bus.mem_rdata[15:8];
      2'd2: byte_sel = bus.mem_rdata[23:16];
      2'd3: byte_sel = bus.mem_rdata[31:24];
      default: byte_sel = bus.mem_rdata[7:0];
    endcase
    half_sel = pend_off_q[1] ? bus.mem_rdata[31:16] : bus.mem_rdata[15:0];

    load_ext = bus.mem_rdata;
    case (pend_f3_q)
      3'b000:  load_ext = {{24{byte_sel[7]}}, byte_sel};
      3'b001:  load_ext = {{16{half_sel[15]}}, half_sel};
      3'b100:  load_ext = {24'd0, byte_sel};
      3'b101:  load_ext = {16'd0, half_sel};
      default: load_ext = bus.mem_rdata;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    pend_rd_d  = pend_rd_q;
    pend_f3_d  = pend_f3_q;
    pend_off_d = pend_off_q;
    is_write_d = 1'b0;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q;

    if (ld_accept) begin
      state_d    = LOAD_WAIT;
      pend_rd_d  = bus.ld_rd;
      pend_f3_d  = bus.ld_funct3;
      pend_off_d = bus.ld_offset;
    end else if (load_rsp) begin
      state_d = IDLE;
    end

    if ((state_q == IDLE) && bus.mem_rvalid) begin
      err_d = 1'b1;
    end

    // Writes to x0 complete the handshake but leave the port untouched.
    if (load_rsp) begin
      if (pend_rd_q != 5'd0) begin
        is_write_d = 1'b1;
        wb_addr_d  = pend_rd_q;
        wb_data_d  = load_ext;
      end
    end else if (alu_accept) begin
      if (bus.alu_rd != 5'd0) begin
        is_write_d = 1'b1;
        wb_addr_d  = bus.alu_rd;
        wb_data_d  = bus.alu_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      pend_rd_q  <= 5'd0;
      pend_f3_q  <= 3'd0;
      pend_off_q <= 2'd0;
      is_write_q <= 1'b0;
      wb_addr_q  <= 5'd0;
      wb_data_q  <= 32'd0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pend_rd_q  <= pend_rd_d;
      pend_f3_q  <= pend_f3_d;
      pend_off_q <= pend_off_d;
      is_write_q <= is_write_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: doc/wb_unit.md
WB_UNIT -- requirements
Module: wb_unit

Interface
REQ-001 SHALL have clk, input, 1, single clock; all state updates on rising edge.
REQ-002 SHALL have rst, input, 1, synchronous active-high reset, sampled on the clk rising edge.
REQ-003 SHALL have alu_valid, input, 1, ALU result offered.
REQ-004 SHALL have alu_rd, input, 5, ALU destination register.
REQ-005 SHALL have alu_data, input, 32, ALU result.
REQ-006 SHALL have alu_ready, output, 1, ALU result accepted this cycle when high together with alu_valid (combinational).
REQ-007 SHALL have ld_issue_valid, input, 1, load issued to memory.
REQ-008 SHALL have ld_rd / ld_funct3 / ld_offset, inputs, 5 / 3 / 2, load destination, RV32I load funct3, address bits [1:0].
REQ-009 SHALL have ld_issue_ready, output, 1, load issue accepted when high with ld_issue_valid (combinational).
REQ-010 SHALL have mem_rvalid / mem_rdata, inputs, 1 / 32, one-cycle memory read response, no backpressure.
REQ-011 SHALL have is_write / wb_addr / wb_data, outputs, 1 / 5 / 32, registered register-file write port.
REQ-012 SHALL have load_pending / load_rd, outputs, 1 / 5, outstanding-load flag and its destination, for hazard detection.
REQ-013 SHALL have err, output, 1, sticky flag for unexpected mem_rvalid.

Function
REQ-014 SHALL implement FSM states IDLE and LOAD_WAIT; load_pending = (state == LOAD_WAIT).
REQ-015 IDLE -> LOAD_WAIT on ld_issue_valid & ld_issue_ready; capture ld_rd, ld_funct3, ld_offset into a pending-load register.
REQ-016 LOAD_WAIT -> IDLE on mem_rvalid, unless a new load is accepted in the same cycle, in which case it SHALL stay in LOAD_WAIT with the new load captured.
REQ-017 ld_issue_ready SHALL equal (state == IDLE) | (state == LOAD_WAIT & mem_rvalid); at most one load outstanding.
REQ-018 alu_ready SHALL equal ~(state == LOAD_WAIT & mem_rvalid); a load response has priority over an ALU result.
REQ-019 The load response SHALL be extended per captured funct3: 000 LB sign-extend byte[offset]; 001 LH sign-extend half[offset[1]]; 010 LW full word; 100 LBU zero-extend byte; 101 LHU zero-extend half; 011/110/111 treated as LW.
REQ-020 Byte lane n SHALL be mem_rdata[8n+7:8n]; half lane h SHALL be mem_rdata[16h+15:16h]; offset[0] is ignored for halfwords, misalignment is handled upstream.
REQ-021 A winning write (load response or accepted ALU result) SHALL appear on is_write/wb_addr/wb_data exactly one cycle later, for exactly one cycle.
REQ-022 When the destination is x0 the handshake SHALL complete but is_write SHALL stay 0 in the following cycle.
REQ-023 With no winning write, is_write SHALL be 0 next cycle; wb_addr and wb_data SHALL hold their last values.
REQ-024 mem_rvalid in IDLE SHALL be ignored (no write) and SHALL set err, which stays 1 until reset.
REQ-025 An ALU write to the same rd as an outstanding load SHALL still be performed; ordering is the pipeline's responsibility via load_pending/load_rd.
REQ-026 load_rd SHALL show the captured destination while load_pending is 1 and hold its value otherwise.

Reset
REQ-027 On rst=1 at a clock edge: state=IDLE, is_write=0, wb_addr=0, wb_data=0, load_rd=0, err=0, pending funct3/offset=0.
REQ-028 rst SHALL take priority over all inputs in the same cycle; an outstanding load is discarded and a later mem_rvalid only sets err.
REQ-029 While rst=1, ld_issue_ready and alu_ready SHALL still follow REQ-017 and REQ-018 from the reset state; accepted transactions have no effect.

Verification
REQ-030 ALU alu_valid=1, rd=5, data=0xDEADBEEF in IDLE -> alu_ready=1; next cycle is_write=1, wb_addr=5, wb_data=0xDEADBEEF; following cycle is_write=0.
REQ-031 Load LB rd=3, offset=2; mem_rdata=0x00800000 two cycles later -> load_pending=1 in between; next cycle wb_addr=3, wb_data=0xFFFFFF80; load_pending=0.
REQ-032 Outstanding LHU rd=7, offset=2; mem_rvalid with mem_rdata=0xBEEF1234 together with alu_valid rd=9 -> alu_ready=0; next cycle write x7=0x0000BEEF; ALU write x9 follows one cycle after.
REQ-033 Back-to-back: LW rd=1 response in the same cycle as a new LW rd=2 issue -> x1 written; state stays LOAD_WAIT; load_rd=2.
REQ-034 ALU rd=0, data=0x1 -> alu_ready=1, is_write stays 0; then mem_rvalid=1 in IDLE -> err=1, no write; rst=1 -> err=0.
REQ-035 Reset mid-load: LW rd=4 issued, rst pulsed, then mem_rvalid -> no write to x4; err=1; load_pending=0 throughout after reset.
